// File: rtl/gate_sweep_pkg.sv
// rtl/gate_sweep_pkg.sv - shared op encodings and FSM state type for gate_sweep
package gate_sweep_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_NAND = 3'd3;
   localparam logic [2:0] OP_NOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_NOT  = 3'd6;
   localparam logic [2:0] OP_BUF  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/gate_sweep_reduce.sv
// rtl/gate_sweep_reduce.sv - combinational N-input reduction gate selected by op
module gate_reduce
   import gate_sweep_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0] vec,
   input  logic [2:0]   op,
   output logic         res
);

   always_comb begin
      res = 1'b0;
      case (op)
         OP_AND:  res = &vec;
         OP_OR:   res = |vec;
         OP_XOR:  res = ^vec;
         OP_NAND: res = ~&vec;
         OP_NOR:  res = ~|vec;
         OP_XNOR: res = ~^vec;
         // single-input gates look only at the least significant input
         OP_NOT:  res = ~vec[0];
         OP_BUF:  res = vec[0];
         default: res = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_sweep.sv
// rtl/gate_sweep.sv - self-sequencing sweep of a reduction gate over all 2^N inputs
module gate_sweep
   import gate_sweep_pkg::*;
#(
   parameter int N = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [2:0]          op,
   input  logic                step_en,
   output logic                busy_o,
   output logic                valid_o,
   output logic [N-1:0]        vec_o,
   output logic                res_o,
   output logic [(1<<N)-1:0]   tt_o,
   output logic                done_o
);

   state_t       state_q;
   state_t       state_d;
   logic [N-1:0] cnt_q;
   logic [2:0]   op_q;
   logic         gate_res;

   gate_reduce #(.N(N)) u_reduce (
      .vec (cnt_q),
      .op  (op_q),
      .res (gate_res)
   );

   assign busy_o = (state_q != ST_IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_SWEEP;
         ST_SWEEP: if (step_en && (cnt_q == '1)) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         valid_o <= 1'b0;
         vec_o   <= '0;
         res_o   <= 1'b0;
         tt_o    <= '0;
         done_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_o <= 1'b0;
         done_o  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  op_q  <= op;
                  cnt_q <= '0;
                  tt_o  <= '0;
               end
            end
            ST_SWEEP: begin
               // a low step_en freezes the sweep and leaves a gap in valid_o
               if (step_en) begin
                  vec_o       <= cnt_q;
                  res_o       <= gate_res;
                  tt_o[cnt_q] <= gate_res;
                  valid_o     <= 1'b1;
                  cnt_q       <= cnt_q + N'(1);
               end
            end
            ST_DONE: done_o <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_sweep.sv
// tb/tb_gate_sweep.sv - scoreboard bench for gate_sweep at N=2, N=3 and N=1
module tb_gate_sweep;

   typedef struct {
      int         id;
      logic [7:0] vec;
      logic       res;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] start_v = '0;
   logic [2:0] op = '0;
   logic       step_en = 1'b1;
   logic [2:0] busy_v, valid_v, res_v, done_v;
   logic [1:0] vec0;
   logic [2:0] vec1;
   logic [0:0] vec2;
   logic [3:0] tt0;
   logic [7:0] tt1;
   logic [1:0] tt2;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   done_cnt[3] = '{0, 0, 0};

   always #5 clk = ~clk;

   gate_sweep #(.N(2)) u_n2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op(op), .step_en(step_en),
      .busy_o(busy_v[0]), .valid_o(valid_v[0]), .vec_o(vec0), .res_o(res_v[0]),
      .tt_o(tt0), .done_o(done_v[0])
   );
   gate_sweep #(.N(3)) u_n3 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op(op), .step_en(step_en),
      .busy_o(busy_v[1]), .valid_o(valid_v[1]), .vec_o(vec1), .res_o(res_v[1]),
      .tt_o(tt1), .done_o(done_v[1])
   );
   gate_sweep #(.N(1)) u_n1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .op(op), .step_en(step_en),
      .busy_o(busy_v[2]), .valid_o(valid_v[2]), .vec_o(vec2), .res_o(res_v[2]),
      .tt_o(tt2), .done_o(done_v[2])
   );

   function automatic logic [7:0] vec_of(int i);
      case (i)
         0:       return {6'b0, vec0};
         1:       return {5'b0, vec1};
         default: return {7'b0, vec2};
      endcase
   endfunction

   function automatic logic [7:0] tt_of(int i);
      case (i)
         0:       return {4'b0, tt0};
         1:       return tt1;
         default: return {6'b0, tt2};
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (done_v[i]) done_cnt[i]++;
         if (valid_v[i]) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("unexpected_valid_n%0d", i), 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("valid_inst", i, e.id);
               chk($sformatf("vec_n%0d", i), vec_of(i), e.vec);
               chk($sformatf("res_n%0d_v%0d", i, e.vec), res_v[i], e.res);
            end
         end
      end
   end

   // Runs one sweep; cycles are counted as edges after the start-sampling edge.
   task automatic run_sweep(input int i, input logic [2:0] o, input logic [7:0] tt_exp,
                            input int exp_cyc, input int pause_after, input int pause_len,
                            input logic glitch);
      int n, sz, cyc, dc;
      n  = (i == 0) ? 2 : (i == 1) ? 3 : 1;
      sz = 1 << n;
      dc = done_cnt[i];
      for (int k = 0; k < sz; k++) exp_q.push_back('{i, 8'(k), tt_exp[k]});
      @(posedge clk); #1;
      op = o;
      start_v[i] = 1'b1;
      @(posedge clk); #1;
      start_v[i] = 1'b0;
      chk("busy_after_start", busy_v[i], 1'b1);
      chk("tt_cleared", tt_of(i), 8'h0);
      cyc = 0;
      while (!done_v[i] && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == pause_after + 1) step_en = 1'b0;
         if (cyc == pause_after + 1 + pause_len) step_en = 1'b1;
         if (glitch && cyc == 2) begin
            start_v[i] = 1'b1;
            op = ~o;
         end
      end
      start_v[i] = 1'b0;
      step_en = 1'b1;
      chk($sformatf("done_cycle_n%0d_op%0d", i, o), cyc, exp_cyc);
      chk($sformatf("busy_at_done_n%0d", i), busy_v[i], 1'b0);
      chk($sformatf("tt_n%0d_op%0d", i, o), tt_of(i), tt_exp);
      @(posedge clk); #1;
      chk("done_one_cycle", done_v[i], 1'b0);
      chk("stays_idle", busy_v[i], 1'b0);
      chk("tt_holds", tt_of(i), tt_exp);
      chk("done_count", done_cnt[i] - dc, 1);
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask

   initial begin
      int dc;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", busy_v, 3'b0);
      chk("reset_valid", valid_v, 3'b0);
      chk("reset_done", done_v, 3'b0);
      chk("reset_res", res_v, 3'b0);
      chk("reset_tt", {tt0, tt1, tt2}, 14'h0);
      chk("reset_vec", {vec0, vec1, vec2}, 6'h0);
      @(negedge clk);
      rst_n = 1'b1;

      run_sweep(0, 3'd0, 8'b1000, 5, -10, 0, 1'b0);
      run_sweep(0, 3'd1, 8'b1110, 5, -10, 0, 1'b0);
      run_sweep(0, 3'd6, 8'b0101, 5, -10, 0, 1'b0);
      run_sweep(0, 3'd5, 8'b1001, 5, -10, 0, 1'b0);
      run_sweep(1, 3'd2, 8'h96, 11, 3, 2, 1'b0);
      run_sweep(1, 3'd2, 8'h96, 9, -10, 0, 1'b0);
      // BUF latched; op flips to AND and start is held through SWEEP and DONE
      run_sweep(0, 3'd7, 8'b1010, 5, -10, 0, 1'b1);
      run_sweep(2, 3'd3, 8'b01, 3, -10, 0, 1'b0);

      // asynchronous reset mid-sweep, right after vec 1 is presented
      dc = done_cnt[0];
      exp_q.push_back('{0, 8'd0, 1'b0});
      exp_q.push_back('{0, 8'd1, 1'b1});
      @(posedge clk); #1;
      op = 3'd1;
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_busy", busy_v[0], 1'b0);
      chk("rst_valid", valid_v[0], 1'b0);
      chk("rst_vec", vec0, 2'b0);
      chk("rst_res", res_v[0], 1'b0);
      chk("rst_tt", tt0, 4'b0);
      chk("rst_done", done_v[0], 1'b0);
      chk("rst_sb_drained", exp_q.size(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("post_rst_idle", busy_v[0], 1'b0);
      chk("post_rst_no_done", done_cnt[0] - dc, 0);
      run_sweep(0, 3'd4, 8'b0001, 5, -10, 0, 1'b0);

      repeat (3) @(posedge clk);
      chk("final_sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
